// File: rtl/cfd_prog_pkg.sv
// Shared definitions for the CFD serial programming block.
//   state_e         : programming FSM states (IDLE/SHIFT/STROBE/GAP)
//   DEF_*           : default parameter values used by cfd_serial_prog
//   calc_framebits  : width of one serial frame (MODE + ADDR + DATA)
package cfd_prog_pkg;

  localparam int DEF_ADDRBITS = 4;
  localparam int DEF_DATABITS = 6;
  localparam int DEF_MODEBITS = 4;
  localparam int DEF_CHANNELS = 16;
  localparam int DEF_CLKDIV   = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_STROBE = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  function automatic int calc_framebits(input int modebits, input int addrbits,
                                        input int databits);
    return modebits + addrbits + databits;
  endfunction

endpackage

// File: rtl/cfd_sclk_gen.sv
// Serial clock divider for cfd_serial_prog.
// Counts CLKDIV system clocks per SI_CLK half-period and produces:
//   clk_i    : system clock
//   rst_ni   : synchronous active-low reset
//   clear_i  : restart the divider (held while the FSM is idle)
//   toggle_i : let the serial clock toggle at the next half-period boundary;
//              when low the serial clock is forced low at that boundary
//   tick_o   : high in the last system cycle of each half-period
//   sclk_o   : registered serial clock level
module cfd_sclk_gen #(
  parameter int CLKDIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic toggle_i,
  output logic tick_o,
  output logic sclk_o
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [DW-1:0] div_q;
  logic          sclk_q;

  assign tick_o = (div_q == DW'(CLKDIV - 1));
  assign sclk_o = sclk_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else if (tick_o) begin
      div_q  <= '0;
      // Outside bit phases the clock always lands low, so STROBE/GAP and the
      // first half of every new bit see SI_CLK=0.
      sclk_q <= toggle_i & ~sclk_q;
    end else begin
      div_q  <= div_q + DW'(1);
    end
  end

endmodule

// File: rtl/cfd_serial_prog.sv
// Serial programming engine for a CFD chip's per-channel mode/threshold
// registers. A request is shifted out MSB first as {MODE, ADDR, DATA} on
// SI/SI_CLK, latched with STB, followed by an idle GAP. Broadcast repeats the
// frame for every channel address; readback shifts SO in on SO_CLK.
//
// Handshake: REQ_VALID/REQ_READY is a strict valid/ready pair. A request is
// taken on the rising edge where both are high; REQ_READY is high only in
// IDLE, and REQ_VALID seen while busy is ignored (never queued).
//
// Ports:
//   CLK, RST_N               clock, synchronous active-low reset
//   REQ_VALID/REQ_READY      request handshake
//   REQ_BCAST, REQ_RDBK      broadcast to all channels / capture readback
//   REQ_MODE/ADDR/DATA       frame fields
//   SI, SI_CLK, STB          serial data, serial clock, load strobe
//   SO, SO_CLK               readback data in, readback clock out
//   RD_DATA, RD_VALID        last readback word, one-cycle update pulse
//   BUSY                     high whenever the FSM is not idle
//   DBG_STATE                current FSM state (cfd_prog_pkg::state_e)
module cfd_serial_prog
  import cfd_prog_pkg::*;
#(
  parameter int ADDRBITS = DEF_ADDRBITS,
  parameter int DATABITS = DEF_DATABITS,
  parameter int MODEBITS = DEF_MODEBITS,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CLKDIV   = DEF_CLKDIV
) (
  input  logic                                   CLK,
  input  logic                                   RST_N,
  input  logic                                   REQ_VALID,
  output logic                                   REQ_READY,
  input  logic                                   REQ_BCAST,
  input  logic                                   REQ_RDBK,
  input  logic [MODEBITS-1:0]                    REQ_MODE,
  input  logic [ADDRBITS-1:0]                    REQ_ADDR,
  input  logic [DATABITS-1:0]                    REQ_DATA,
  output logic                                   SI,
  output logic                                   SI_CLK,
  output logic                                   STB,
  input  logic                                   SO,
  output logic                                   SO_CLK,
  output logic [MODEBITS+ADDRBITS+DATABITS-1:0]  RD_DATA,
  output logic                                   RD_VALID,
  output logic                                   BUSY,
  output logic [1:0]                             DBG_STATE
);

  localparam int FRAMEBITS = calc_framebits(MODEBITS, ADDRBITS, DATABITS);
  localparam int BW = (FRAMEBITS > 1) ? $clog2(FRAMEBITS) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  state_e                 state_q;
  logic [FRAMEBITS-1:0]   shreg_q;
  logic [FRAMEBITS-1:0]   cap_q;
  logic [FRAMEBITS-1:0]   rd_data_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [CW-1:0]          chan_cnt_q;
  logic [CW-1:0]          chan_nxt;
  logic [MODEBITS-1:0]    mode_q;
  logic [DATABITS-1:0]    data_q;
  logic                   bcast_q;
  logic                   rdbk_q;
  logic                   stb_q;
  logic                   rd_valid_q;

  logic                   tick;
  logic                   sclk;

  function automatic logic [FRAMEBITS-1:0] build_frame(
    input logic [MODEBITS-1:0] m,
    input logic [ADDRBITS-1:0] a,
    input logic [DATABITS-1:0] d
  );
    return {m, a, d};
  endfunction

  cfd_sclk_gen #(
    .CLKDIV (CLKDIV)
  ) u_sclk_gen (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .clear_i  (state_q == ST_IDLE),
    .toggle_i (state_q == ST_SHIFT),
    .tick_o   (tick),
    .sclk_o   (sclk)
  );

  assign chan_nxt = chan_cnt_q + CW'(1);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      cap_q      <= '0;
      rd_data_q  <= '0;
      bit_cnt_q  <= '0;
      chan_cnt_q <= '0;
      mode_q     <= '0;
      data_q     <= '0;
      bcast_q    <= 1'b0;
      rdbk_q     <= 1'b0;
      stb_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (REQ_VALID) begin
            bcast_q    <= REQ_BCAST;
            rdbk_q     <= REQ_RDBK;
            mode_q     <= REQ_MODE;
            data_q     <= REQ_DATA;
            bit_cnt_q  <= '0;
            chan_cnt_q <= '0;
            cap_q      <= '0;
            // Broadcast always starts at channel 0; REQ_ADDR is don't-care.
            shreg_q    <= build_frame(REQ_MODE, REQ_BCAST ? '0 : REQ_ADDR, REQ_DATA);
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // End of a bit: last cycle of the SI_CLK high half.
          if (tick && sclk) begin
            shreg_q <= {shreg_q[FRAMEBITS-2:0], 1'b0};
            if (rdbk_q) cap_q <= {cap_q[FRAMEBITS-2:0], SO};
            if (bit_cnt_q == BW'(FRAMEBITS - 1)) begin
              bit_cnt_q <= '0;
              stb_q     <= 1'b1;
              state_q   <= ST_STROBE;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
        end
        ST_STROBE: begin
          if (tick) begin
            stb_q   <= 1'b0;
            state_q <= ST_GAP;
            if (rdbk_q) begin
              rd_data_q  <= cap_q;
              rd_valid_q <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (bcast_q && (chan_cnt_q != CW'(CHANNELS - 1))) begin
              chan_cnt_q <= chan_nxt;
              cap_q      <= '0;
              shreg_q    <= build_frame(mode_q, ADDRBITS'(chan_nxt), data_q);
              state_q    <= ST_SHIFT;
            end else begin
              chan_cnt_q <= '0;
              state_q    <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The shift register empties to zero by the end of each frame, so its MSB
  // is also the idle-low SI level.
  assign SI        = shreg_q[FRAMEBITS-1];
  assign SI_CLK    = sclk;
  assign SO_CLK    = sclk & rdbk_q;
  assign STB       = stb_q;
  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign REQ_READY = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_cfd_serial_prog.sv
// Directed bench for cfd_serial_prog: default instance (CLKDIV=4, 14-bit
// frame) and a fast instance (CLKDIV=1, DATABITS=8, 16-bit frame).
module tb_cfd_serial_prog;

  logic clk;
  logic rst_n;

  // instance A: defaults
  logic        a_valid, a_ready, a_bcast, a_rdbk;
  logic [3:0]  a_mode, a_addr;
  logic [5:0]  a_data;
  logic        a_si, a_sclk, a_stb, a_so_clk, a_rd_valid, a_busy;
  logic [13:0] a_rd_data;
  logic [1:0]  a_dbg;

  // instance B: CLKDIV=1, DATABITS=8
  logic        b_valid, b_ready, b_bcast, b_rdbk;
  logic [3:0]  b_mode, b_addr;
  logic [7:0]  b_data;
  logic        b_si, b_sclk, b_stb, b_so_clk, b_rd_valid, b_busy;
  logic [15:0] b_rd_data;
  logic [1:0]  b_dbg;

  logic so_drive;

  cfd_serial_prog u_dut_a (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(a_valid), .REQ_READY(a_ready), .REQ_BCAST(a_bcast), .REQ_RDBK(a_rdbk),
    .REQ_MODE(a_mode), .REQ_ADDR(a_addr), .REQ_DATA(a_data),
    .SI(a_si), .SI_CLK(a_sclk), .STB(a_stb), .SO(so_drive), .SO_CLK(a_so_clk),
    .RD_DATA(a_rd_data), .RD_VALID(a_rd_valid), .BUSY(a_busy), .DBG_STATE(a_dbg)
  );

  cfd_serial_prog #(.CLKDIV(1), .DATABITS(8)) u_dut_b (
    .CLK(clk), .RST_N(rst_n),
    .REQ_VALID(b_valid), .REQ_READY(b_ready), .REQ_BCAST(b_bcast), .REQ_RDBK(b_rdbk),
    .REQ_MODE(b_mode), .REQ_ADDR(b_addr), .REQ_DATA(b_data),
    .SI(b_si), .SI_CLK(b_sclk), .STB(b_stb), .SO(so_drive), .SO_CLK(b_so_clk),
    .RD_DATA(b_rd_data), .RD_VALID(b_rd_valid), .BUSY(b_busy), .DBG_STATE(b_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor mux ----------------
  logic        sel;  // 0: instance A, 1: instance B
  logic        m_si, m_sclk, m_stb, m_so_clk, m_rd_valid, m_busy, m_ready;
  logic [15:0] m_rd_data;
  logic [1:0]  m_dbg;
  assign m_si       = sel ? b_si       : a_si;
  assign m_sclk     = sel ? b_sclk     : a_sclk;
  assign m_stb      = sel ? b_stb      : a_stb;
  assign m_so_clk   = sel ? b_so_clk   : a_so_clk;
  assign m_rd_valid = sel ? b_rd_valid : a_rd_valid;
  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_ready    = sel ? b_ready    : a_ready;
  assign m_rd_data  = sel ? b_rd_data  : {2'b00, a_rd_data};
  assign m_dbg      = sel ? b_dbg      : a_dbg;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- frame statistics ----------------
  int          n_rise, n_hi, n_stb, stb_first, stb_last, busy_cyc;
  int          rdv_cnt, rdv_cyc, ready_first, wave_err;
  logic [15:0] cap;
  logic [15:0] so_word;

  // Observe ncyc cycles (cycle 1 = first cycle after the accepting edge),
  // sampling on the falling edge. SI is recorded at each SI_CLK rise and
  // compared against the expected queue at each STB rise. SO is presented
  // bit by bit, MSB first, when SO_CLK rises.
  task automatic watch(input int ncyc, input int fb);
    int so_idx;
    logic p_sclk, p_so_clk, p_stb;
    logic [15:0] mask, w;
    mask = (fb == 16) ? 16'hFFFF : 16'h3FFF;
    so_idx = fb - 1;
    p_sclk = 1'b0; p_so_clk = 1'b0; p_stb = 1'b0;
    n_rise = 0; n_hi = 0; n_stb = 0; stb_first = -1; stb_last = -1;
    busy_cyc = 0; rdv_cnt = 0; rdv_cyc = -1; ready_first = -1; wave_err = 0;
    cap = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (m_sclk) n_hi++;
      if (m_sclk && !p_sclk) begin
        n_rise++;
        cap = {cap[14:0], m_si};
      end
      if (m_so_clk && !p_so_clk && so_idx >= 0) begin
        so_drive = so_word[so_idx];
        so_idx--;
      end
      if (m_stb && !p_stb) begin
        n_stb++;
        if (exp_q.size() == 0) check("sb_unexpected_frame", 32'(cap & mask), 32'hFFFF_FFFF);
        else begin
          w = exp_q.pop_front();
          check("sb_frame", 32'(cap & mask), 32'(w));
        end
        cap = '0;
      end
      if (m_stb) begin
        if (stb_first < 0) stb_first = c;
        stb_last = c;
        if (m_sclk || m_si) wave_err++;
      end
      if (m_busy) busy_cyc++;
      if (m_rd_valid) begin rdv_cnt++; rdv_cyc = c; end
      if (m_ready && ready_first < 0) ready_first = c;
      if (m_busy == m_ready) wave_err++;
      p_sclk = m_sclk; p_so_clk = m_so_clk; p_stb = m_stb;
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_req(input logic bc, input logic rd, input logic [3:0] m,
                           input logic [3:0] a, input logic [7:0] d);
    if (!sel) begin
      a_bcast = bc; a_rdbk = rd; a_mode = m; a_addr = a; a_data = d[5:0]; a_valid = 1'b1;
    end else begin
      b_bcast = bc; b_rdbk = rd; b_mode = m; b_addr = a; b_data = d; b_valid = 1'b1;
    end
  endtask

  task automatic release_req();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Present a request with READY high; returns just after the accepting edge.
  task automatic accept(input logic bc, input logic rd, input logic [3:0] m,
                        input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    check("ready_before_accept", 32'(m_ready), 32'd1);
    drive_req(bc, rd, m, a, d);
    @(posedge clk);
    #1 release_req();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    sel = 1'b0; so_drive = 1'b0; so_word = '0;
    a_valid = 0; a_bcast = 0; a_rdbk = 0; a_mode = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_bcast = 0; b_rdbk = 0; b_mode = 0; b_addr = 0; b_data = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",    32'(a_ready),    32'd1);
    check("rst_busy",     32'(a_busy),     32'd0);
    check("rst_idle_pins", 32'({a_si, a_sclk, a_so_clk, a_stb, a_rd_valid}), 32'd0);
    check("rst_rd_data",  32'(a_rd_data),  32'd0);
    check("rst_b_idle",   32'({b_busy, b_si, b_sclk, b_stb}), 32'd0);
    rst_n = 1'b1;

    // 1) single write MODE=3 ADDR=5 DATA=2A -> 0011_0101_101010
    exp_q.push_back(16'h0D6A);
    accept(1'b0, 1'b0, 4'h3, 4'h5, 8'h2A);
    watch(121, 14);
    check("w_sclk_rises", n_rise, 14);
    check("w_sclk_hi_cyc", n_hi, 56);
    check("w_stb_first", stb_first, 113);
    check("w_stb_last", stb_last, 116);
    check("w_busy_cycles", busy_cyc, 120);
    check("w_ready_cycle", ready_first, 121);
    check("w_no_rd_valid", rdv_cnt, 0);
    check("w_wave", wave_err, 0);

    // 2) broadcast MODE=1 DATA=3F -> addresses 0..15
    for (int i = 0; i < 16; i++) exp_q.push_back(16'((1 << 10) | (i << 6) | 16'h3F));
    accept(1'b1, 1'b0, 4'h1, 4'h9, 8'h3F);
    watch(1921, 14);
    check("bc_stb_pulses", n_stb, 16);
    check("bc_busy_cycles", busy_cyc, 1920);
    check("bc_ready_cycle", ready_first, 1921);
    check("bc_wave", wave_err, 0);

    // 3) readback: SO carries 14'h2A5C
    exp_q.push_back(16'h2715);
    so_word = 16'h2A5C;
    accept(1'b0, 1'b1, 4'h9, 4'hC, 8'h15);
    watch(121, 14);
    check("rb_rd_valid_cnt", rdv_cnt, 1);
    check("rb_rd_valid_cyc", rdv_cyc, 117);
    check("rb_rd_data", 32'(m_rd_data), 32'h2A5C);
    check("rb_so_clk_idle", 32'(m_so_clk), 32'd0);

    // 4) REQ_VALID held with new fields while busy: first frame untouched,
    //    second taken on the first edge where READY is high.
    exp_q.push_back(16'h188F);
    exp_q.push_back(16'h3F80);
    so_word = '0;
    @(negedge clk);
    drive_req(1'b0, 1'b0, 4'h6, 4'h2, 8'h0F);
    @(posedge clk);
    #1 drive_req(1'b0, 1'b0, 4'hF, 4'hE, 8'h00);
    watch(121, 14);
    check("hold_busy_cycles", busy_cyc, 120);
    check("hold_ready_cycle", ready_first, 121);
    check("hold_rd_data_kept", 32'(m_rd_data), 32'h2A5C);
    @(posedge clk);
    #1 release_req();
    watch(121, 14);
    check("hold_second_stb", stb_first, 113);
    check("hold_second_busy", busy_cyc, 120);

    // 5) reset at cycle 50 of a readback frame
    accept(1'b0, 1'b1, 4'h5, 4'h5, 8'h3F);
    watch(49, 14);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_ready", 32'(a_ready), 32'd1);
    check("mr_busy", 32'(a_busy), 32'd0);
    check("mr_pins", 32'({a_si, a_sclk, a_so_clk, a_stb, a_rd_valid}), 32'd0);
    check("mr_rd_data", 32'(a_rd_data), 32'd0);
    check("mr_state", 32'(m_dbg), 32'd0);
    rst_n = 1'b1;
    watch(130, 14);
    check("mr_no_stb", n_stb, 0);
    check("mr_no_rd_valid", rdv_cnt, 0);
    check("mr_stays_idle", busy_cyc, 0);

    // 6) CLKDIV=1, DATABITS=8: 34-cycle frame, 2-cycle bits
    sel = 1'b1;
    exp_q.push_back(16'hA6C3);
    so_word = 16'h5A96;
    accept(1'b0, 1'b1, 4'hA, 4'h6, 8'hC3);
    watch(35, 16);
    check("f_sclk_rises", n_rise, 16);
    check("f_sclk_hi_cyc", n_hi, 16);
    check("f_stb_cycle", stb_first, 33);
    check("f_stb_len", stb_last, 33);
    check("f_busy_cycles", busy_cyc, 34);
    check("f_ready_cycle", ready_first, 35);
    check("f_rd_valid_cyc", rdv_cyc, 34);
    check("f_rd_data", 32'(m_rd_data), 32'h5A96);

    check("sb_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
